// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg
//   Shared definitions for the EX->MEM stage register: default field widths,
//   NOP bundle encodings driven downstream while the stage is empty, the
//   reset-active level and the skid buffer state encoding.
package pipe_stage_buf_pkg;

    localparam int ALUOP_W_DEF  = 7;
    localparam int FUNCT3_W_DEF = 3;
    localparam int ADDR_W_DEF   = 32;
    localparam int RADDR_W_DEF  = 5;
    localparam int DATA_W_DEF   = 32;
    localparam int CNT_W_DEF    = 16;

    localparam logic        RstEnable  = 1'b1;
    localparam logic [6:0]  NOP        = 7'b0010011;
    localparam logic [2:0]  NOP_FUNCT3 = 3'b000;
    localparam logic [31:0] NopMem     = 32'h0000_0000;
    localparam logic [4:0]  NopRegAddr = 5'b00000;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    // Bit 1 = main entry valid, bit 0 = skid entry valid, so the handshake
    // outputs decode from a single state bit each.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_e;

endpackage

// File: rtl/pipe_stage_buf_skid.sv
// skid_buf2
//   Generic two-entry valid/ready skid buffer on an opaque payload.
//   in_ready depends only on registered state, so there is no combinational
//   path from out_ready back to the producer. flush empties both entries.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous kill of both entries (beats accept/drain)
//   in_valid/ready  producer handshake, in_data payload
//   out_valid/ready consumer handshake, out_data payload (main entry)
module skid_buf2
    import pipe_stage_buf_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state_r;
    buf_state_e   state_nxt_s;
    logic [W-1:0] main_r;
    logic [W-1:0] skid_r;
    logic         accept_s;
    logic         drain_s;
    logic         load_main_s;
    logic         load_skid_s;
    logic         main_from_skid_s;

    assign in_ready  = ~state_r[0];
    assign out_valid = state_r[1];
    assign out_data  = main_r;

    assign accept_s = in_valid & ~state_r[0];
    assign drain_s  = state_r[1] & out_ready;

    // Next-state and payload load decisions.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            state_nxt_s = BUF_EMPTY;
        end else begin
            case (state_r)
                BUF_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = BUF_ONE;
                        load_main_s = 1'b1;
                    end else begin
                        state_nxt_s = BUF_EMPTY;
                    end
                end
                BUF_ONE: begin
                    if (drain_s && accept_s) begin
                        state_nxt_s = BUF_ONE;
                        load_main_s = 1'b1;
                    end else if (drain_s) begin
                        state_nxt_s = BUF_EMPTY;
                    end else if (accept_s) begin
                        state_nxt_s = BUF_FULL;
                        load_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = BUF_ONE;
                    end
                end
                BUF_FULL: begin
                    if (drain_s) begin
                        state_nxt_s      = BUF_ONE;
                        load_main_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = BUF_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding (skid valid without main): recover to empty.
                    state_nxt_s = BUF_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_r <= BUF_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Main entry payload; loads only on an accept into main or a skid promotion.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            main_r <= {W{1'b0}};
        end else if (load_main_s) begin
            main_r <= main_from_skid_s ? skid_r : in_data;
        end else begin
            main_r <= main_r;
        end
    end

    // Skid entry payload; loads only when the consumer stalls with main occupied.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            skid_r <= {W{1'b0}};
        end else if (load_skid_s) begin
            skid_r <= in_data;
        end else begin
            skid_r <= skid_r;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   EX->MEM pipeline stage register with valid/ready handshake, a two-entry
//   skid buffer and synchronous flush. Presents a NOP bundle whenever the
//   stage is empty and counts cycles in which MEM stalls a valid bundle.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 kill all held bundles (mispredict / trap)
//   in_valid, in_ready    EX handshake; in_* EX result bundle
//   out_valid, out_ready  MEM handshake; out_* MEM bundle (NOP when empty)
//   stall_cnt             saturating count of out_valid && !out_ready cycles
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int ALUOP_W  = ALUOP_W_DEF,
    parameter int FUNCT3_W = FUNCT3_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RADDR_W  = RADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALUOP_W-1:0]  in_aluop,
    input  logic [FUNCT3_W-1:0] in_funct3,
    input  logic                in_me,
    input  logic [ADDR_W-1:0]   in_maddr,
    input  logic                in_wreg,
    input  logic [RADDR_W-1:0]  in_wd,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALUOP_W-1:0]  out_aluop,
    output logic [FUNCT3_W-1:0] out_funct3,
    output logic                out_me,
    output logic [ADDR_W-1:0]   out_maddr,
    output logic                out_wreg,
    output logic [RADDR_W-1:0]  out_wd,
    output logic [DATA_W-1:0]   out_wdata,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int PAY_W = ALUOP_W + FUNCT3_W + 1 + ADDR_W + 1 + RADDR_W + DATA_W;

    logic [PAY_W-1:0]    pay_in_s;
    logic [PAY_W-1:0]    pay_out_s;
    logic                valid_s;
    logic [ALUOP_W-1:0]  main_aluop_s;
    logic [FUNCT3_W-1:0] main_funct3_s;
    logic                main_me_s;
    logic [ADDR_W-1:0]   main_maddr_s;
    logic                main_wreg_s;
    logic [RADDR_W-1:0]  main_wd_s;
    logic [DATA_W-1:0]   main_wdata_s;
    logic [CNT_W-1:0]    stall_cnt_r;

    assign pay_in_s = {in_aluop, in_funct3, in_me, in_maddr, in_wreg, in_wd, in_wdata};

    skid_buf2 #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in_s),
        .out_valid (valid_s),
        .out_ready (out_ready),
        .out_data  (pay_out_s)
    );

    assign {main_aluop_s, main_funct3_s, main_me_s, main_maddr_s,
            main_wreg_s, main_wd_s, main_wdata_s} = pay_out_s;

    assign out_valid = valid_s;
    assign stall_cnt = stall_cnt_r;

    // Output bundle: main entry when valid, otherwise a side-effect-free NOP.
    always_comb begin
        out_aluop  = ALUOP_W'(NOP);
        out_funct3 = FUNCT3_W'(NOP_FUNCT3);
        out_me     = 1'b0;
        out_maddr  = ADDR_W'(NopMem);
        out_wreg   = 1'b0;
        out_wd     = RADDR_W'(NopRegAddr);
        out_wdata  = DATA_W'(ZeroWord);
        if (valid_s) begin
            out_aluop  = main_aluop_s;
            out_funct3 = main_funct3_s;
            out_me     = main_me_s;
            out_maddr  = main_maddr_s;
            out_wreg   = main_wreg_s;
            out_wd     = main_wd_s;
            out_wdata  = main_wdata_s;
        end else begin
            out_aluop  = ALUOP_W'(NOP);
        end
    end

    // Saturating stall counter; flush does not clear it, only reset does.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (valid_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule
